// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LCD timing / test-pattern generator.
//   BAR_LUT      : 8 reference colour-bar entries, 8 bits per channel, {R,G,B}
//   MODE_*       : pattern select encodings for the mode input
//   axis_total   : total clocks (or lines) of one axis from its four regions
//   cnt_width    : counter width able to hold 0..n-1
package lcd_pattern_pkg;

  localparam logic [1:0] MODE_BAR   = 2'd0;
  localparam logic [1:0] MODE_GRID  = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_LUT [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pattern-generator bus: control inputs plus the LCD output bundle.
//   pix_en, mode, solid_rgb            : controls into the generator
//   lcd_de, lcd_hs, lcd_vs, lcd_rgb    : panel timing and pixel data
//   frame_start                        : one-clock pulse on the first active pixel
// master = generator side, slave = consumer/controller side.
interface lcd_pattern_gen_if #(
  parameter int unsigned DW = 8
);
  logic              pix_en;
  logic [1:0]        mode;
  logic [3*DW-1:0]   solid_rgb;
  logic              lcd_de;
  logic              lcd_hs;
  logic              lcd_vs;
  logic [3*DW-1:0]   lcd_rgb;
  logic              frame_start;

  modport master (
    input  pix_en, mode, solid_rgb,
    output lcd_de, lcd_hs, lcd_vs, lcd_rgb, frame_start
  );

  modport slave (
    output pix_en, mode, solid_rgb,
    input  lcd_de, lcd_hs, lcd_vs, lcd_rgb, frame_start
  );
endinterface

// File: rtl/lcd_pattern_gen_sync_timer.sv
// lcd_sync_timer: horizontal/vertical position counters and raw timing.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   pix_en         : counters advance only when high
//   h_cnt, v_cnt   : current position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   de_raw         : inside the active area
//   hs_raw, vs_raw : active-low sync, low during the sync region of each axis
module lcd_sync_timer
  import lcd_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 13,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 29,
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = cnt_width(H_TOTAL),
  localparam int unsigned VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          de_raw,
  output logic          hs_raw,
  output logic          vs_raw
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Inclusive last-index compare keeps the constants in range even with a
  // zero-length back porch.
  assign de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: parametrised LCD timing and test-pattern source.
//   sys_clk, sys_rst_n : pixel clock, asynchronous active-low reset
//   lcd (master)       : pix_en/mode/solid_rgb in; lcd_de/hs/vs/rgb and
//                        frame_start out, all registered one pix_en step
//                        after the counter state that produces them.
// Patterns: 0 colour bar, 1 grid, 2 gray ramp, 3 solid; switched at frame start.
module lcd_pattern_gen
  import lcd_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 13,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned N_BARS   = 8,
  parameter int unsigned GRID     = 32,
  parameter int unsigned DW       = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  lcd_pattern_gen_if.master lcd
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = cnt_width(H_TOTAL);
  localparam int unsigned VW      = cnt_width(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / N_BARS;
  localparam int unsigned PW      = cnt_width(BAR_W);
  localparam int unsigned BIW     = (cnt_width(N_BARS) > 3) ? cnt_width(N_BARS) : 3;

  localparam logic [HW-1:0]  H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0]  V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [PW-1:0]  BAR_LAST   = PW'(BAR_W - 1);
  localparam logic [BIW-1:0] IDX_LAST   = BIW'(N_BARS - 1);

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             de_raw, hs_raw, vs_raw;
  logic             frame_top, line_start;
  logic [1:0]       mode_q, mode_eff;
  logic [3*DW-1:0]  solid_q, solid_eff;
  logic [PW-1:0]    bar_px, px_cur;
  logic [BIW-1:0]   bar_idx, idx_cur;
  logic [23:0]      bar_c;
  logic             grid_on;
  logic [DW-1:0]    ramp;
  logic [3*DW-1:0]  pix;
  logic             de_q, hs_q, vs_q, fs_q;
  logic [3*DW-1:0]  rgb_q;

  lcd_sync_timer #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timer (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .pix_en (lcd.pix_en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .de_raw (de_raw),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw)
  );

  assign frame_top  = (h_cnt == '0) && (v_cnt == '0);
  assign line_start = (h_cnt == '0);

  // The latch and the first pixel of the frame happen on the same step, so
  // (0,0) takes mode/solid straight from the inputs; the rest of the frame
  // uses the latched copy and never tears.
  assign mode_eff  = frame_top ? lcd.mode      : mode_q;
  assign solid_eff = frame_top ? lcd.solid_rgb : solid_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= '0;
      solid_q <= '0;
    end else if (lcd.pix_en && frame_top) begin
      mode_q  <= lcd.mode;
      solid_q <= lcd.solid_rgb;
    end
  end

  // Bar counters track h_cnt; forcing them to zero at h_cnt=0 restarts every
  // line regardless of what they reached during blanking.
  assign px_cur  = line_start ? '0 : bar_px;
  assign idx_cur = line_start ? '0 : bar_idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (lcd.pix_en) begin
      if (px_cur == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= (idx_cur == IDX_LAST) ? idx_cur : idx_cur + 1'b1;
      end else begin
        bar_px  <= px_cur + 1'b1;
        bar_idx <= idx_cur;
      end
    end
  end

  // MSB-aligned channel scaling: narrower DW keeps the top bits, wider DW
  // repeats the byte pattern downward.
  function automatic logic [DW-1:0] scale(input logic [7:0] c);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DW; i++) r[DW-1-i] = c[7 - (i % 8)];
    return r;
  endfunction

  assign bar_c   = BAR_LUT[idx_cur[2:0]];
  assign grid_on = ((32'(h_cnt) & (GRID - 1)) == 32'd0) ||
                   ((32'(v_cnt) & (GRID - 1)) == 32'd0) ||
                   (h_cnt == H_ACT_LAST) || (v_cnt == V_ACT_LAST);
  assign ramp    = DW'(h_cnt);

  always_comb begin
    pix = '0;
    case (mode_eff)
      MODE_BAR:  pix = {scale(bar_c[23:16]), scale(bar_c[15:8]), scale(bar_c[7:0])};
      MODE_GRID: pix = grid_on ? '1 : '0;
      MODE_RAMP: pix = {3{ramp}};
      default:   pix = solid_eff;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= lcd.pix_en && frame_top;
      if (lcd.pix_en) begin
        de_q  <= de_raw;
        hs_q  <= hs_raw;
        vs_q  <= vs_raw;
        rgb_q <= de_raw ? pix : '0;
      end
    end
  end

  assign lcd.lcd_de      = de_q;
  assign lcd.lcd_hs      = hs_q;
  assign lcd.lcd_vs      = vs_q;
  assign lcd.lcd_rgb     = rgb_q;
  assign lcd.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Scoreboard bench for lcd_pattern_gen on a small 16x4 panel geometry.
module tb_lcd_pattern_gen;
  localparam int unsigned HA = 16, HF = 2, HSY = 3, HB = 1;
  localparam int unsigned VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int unsigned NB = 3, GR = 4, DW = 8;
  localparam int unsigned HT = HA + HF + HSY + HB;
  localparam int unsigned VT = VA + VF + VSY + VB;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        fs;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  lcd_pattern_gen_if #(.DW(DW)) lcd();

  lcd_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .N_BARS (NB), .GRID (GR), .DW (DW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .lcd       (lcd)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t        sb_q[$];
  exp_t        last;
  int          tests = 0;
  int          fails = 0;
  int unsigned pos   = 0;
  logic [1:0]  mlat  = 2'd0;
  logic [23:0] slat  = 24'd0;
  int          pen_mode   = 0;
  int          meas_gen   = 0;
  int          meas_scale = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference pixel from screen position, computed from the geometry rules.
  function automatic exp_t ref_pixel(input int unsigned h, input int unsigned v,
                                     input logic [1:0] m, input logic [23:0] s);
    exp_t e;
    int unsigned bi;
    logic [7:0] hb;
    e.de  = (h < HA) && (v < VA);
    e.hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
    e.vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
    e.fs  = 1'b0;
    e.rgb = 24'd0;
    if (e.de) begin
      case (m)
        2'd0: begin
          bi = h / (HA / NB);
          if (bi > NB - 1) bi = NB - 1;
          e.rgb = BARS[bi % 8];
        end
        2'd1: e.rgb = ((h % GR == 0) || (v % GR == 0) || (h == HA - 1) || (v == VA - 1))
                      ? 24'hFFFFFF : 24'h000000;
        2'd2: begin
          hb = h[7:0];
          e.rgb = {hb, hb, hb};
        end
        default: e.rgb = s;
      endcase
    end
    return e;
  endfunction

  // Reference model: one expected output per clock edge.
  always @(posedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      pos  = 0;
      mlat = 2'd0;
      slat = 24'd0;
      e    = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'd0, fs: 1'b0};
      last = e;
    end else if (lcd.pix_en) begin
      if (pos == 0) begin
        mlat = lcd.mode;
        slat = lcd.solid_rgb;
      end
      e    = ref_pixel(pos % HT, pos / HT, mlat, slat);
      e.fs = (pos == 0);
      pos  = (pos + 1) % (HT * VT);
      last = e;
    end else begin
      e    = last;
      e.fs = 1'b0;
    end
    sb_q.push_back(e);
  end

  // Monitor: pops one expectation per clock and measures periods.
  int   cyc = 0, seen_gen = -1, last_fs = -1, last_hsf = -1, de_run = 0;
  logic prev_hs = 1'b1, prev_de = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: got empty queue, want one entry");
      end else begin
        e = sb_q.pop_front();
        if (lcd.lcd_de !== e.de || lcd.lcd_hs !== e.hs || lcd.lcd_vs !== e.vs ||
            lcd.lcd_rgb !== e.rgb || lcd.frame_start !== e.fs) begin
          fails++;
          $display("FAIL pixel@%0t: got de=%b hs=%b vs=%b rgb=%h fs=%b, want de=%b hs=%b vs=%b rgb=%h fs=%b",
                   $time, lcd.lcd_de, lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_rgb, lcd.frame_start,
                   e.de, e.hs, e.vs, e.rgb, e.fs);
        end
      end
      if (seen_gen != meas_gen) begin
        seen_gen = meas_gen;
        last_fs  = -1;
        last_hsf = -1;
        de_run   = 0;
      end
      if (meas_scale != 0) begin
        if (lcd.frame_start) begin
          if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(154 * meas_scale));
          last_fs = cyc;
        end
        if (prev_hs && !lcd.lcd_hs) begin
          if (last_hsf >= 0) chk("line_period", 32'(cyc - last_hsf), 32'(22 * meas_scale));
          last_hsf = cyc;
        end
        if (lcd.lcd_de) begin
          if (!prev_de) de_run = 1;
          else if (de_run > 0) de_run++;
        end else if (prev_de && de_run > 0) begin
          chk("de_width", 32'(de_run), 32'(16 * meas_scale));
          de_run = 0;
        end
      end
      prev_hs = lcd.lcd_hs;
      prev_de = lcd.lcd_de;
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    case (pen_mode)
      0:       lcd.pix_en = 1'b1;
      1:       lcd.pix_en = ~lcd.pix_en;
      2:       lcd.pix_en = ($urandom_range(0, 3) != 0);
      default: lcd.pix_en = 1'b0;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pos(input int unsigned target, input string name);
    int n;
    n = 0;
    while (pos != target && n < 2000) begin
      tick();
      n++;
    end
    if (pos != target) chk(name, 32'(pos), 32'(target));
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    lcd.pix_en    = 1'b0;
    lcd.mode      = 2'd0;
    lcd.solid_rgb = 24'd0;
    last = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'd0, fs: 1'b0};

    run(3);
    chk("rst_de",  32'(lcd.lcd_de), 32'd0);
    chk("rst_hs",  32'(lcd.lcd_hs), 32'd1);
    chk("rst_vs",  32'(lcd.lcd_vs), 32'd1);
    chk("rst_rgb", 32'(lcd.lcd_rgb), 32'd0);
    chk("rst_fs",  32'(lcd.frame_start), 32'd0);

    // Colour bars with sync/period measurement, two frames and a bit.
    sys_rst_n  = 1'b1;
    pen_mode   = 0;
    meas_scale = 1;
    meas_gen++;
    run(2 * 154 + 5);

    // Mode change mid-frame at line 2.
    wait_pos(2 * HT, "wait_line2");
    lcd.mode      = 2'd3;
    lcd.solid_rgb = 24'h123456;
    run(2 * 154);

    lcd.mode = 2'd1;
    run(2 * 154);
    lcd.mode = 2'd2;
    run(2 * 154);

    // pix_en toggling every clock doubles all periods.
    lcd.mode   = 2'd0;
    pen_mode   = 1;
    meas_scale = 2;
    meas_gen++;
    run(2 * 308 + 10);

    // Random strobe and random mode/colour changes.
    meas_scale = 0;
    meas_gen++;
    pen_mode   = 2;
    for (int i = 0; i < 12; i++) begin
      lcd.mode      = 2'($urandom_range(0, 3));
      lcd.solid_rgb = 24'($urandom);
      run(int'($urandom_range(20, 120)));
    end

    // Asynchronous reset at (h=7, v=2).
    pen_mode = 0;
    lcd.mode = 2'd0;
    run(1);
    wait_pos(2 * HT + 7, "wait_h7v2");
    chk("pre_reset_de", 32'(lcd.lcd_de), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("async_de",  32'(lcd.lcd_de), 32'd0);
    chk("async_hs",  32'(lcd.lcd_hs), 32'd1);
    chk("async_vs",  32'(lcd.lcd_vs), 32'd1);
    chk("async_rgb", 32'(lcd.lcd_rgb), 32'd0);
    chk("async_fs",  32'(lcd.frame_start), 32'd0);
    run(2);
    sys_rst_n  = 1'b1;
    pen_mode   = 3;
    lcd.pix_en = 1'b0;
    run(2);
    pen_mode   = 0;
    lcd.pix_en = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("restart_de", 32'(lcd.lcd_de), 32'd1);
    chk("restart_fs", 32'(lcd.frame_start), 32'd1);
    run(3 * HT);

    run(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
